// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin share of one external 4x4 multiplier
// between two requesters, result returned over valid/ready.
module mul_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       iClock,
  input  logic       iReset_n,
  input  logic       iReq0,
  input  logic [3:0] iA0,
  input  logic [3:0] iB0,
  output logic       oAck0,
  input  logic       iReq1,
  input  logic [3:0] iA1,
  input  logic [3:0] iB1,
  output logic       oAck1,
  output logic [3:0] oMulA,
  output logic [3:0] oMulB,
  input  logic [7:0] iMulY,
  output logic       oValid,
  output logic [7:0] oResult,
  output logic       oId,
  input  logic       iReady,
  output logic       oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       rrLast;
  logic       gnt;
  logic       anyReq;
  logic       winner;

  // pick the winner: lone requester, or the one not served last
  always_comb begin
    winner = 1'b0;
    anyReq = iReq0 | iReq1;
    unique case (1'b1)
      (iReq0 && iReq1):  winner = ~rrLast;
      (iReq1 && !iReq0): winner = 1'b1;
      default:           winner = 1'b0;
    endcase
  end

  // arbitration FSM with registered acks, operands and result
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rrLast  <= 1'b1;
      gnt     <= 1'b0;
      oAck0   <= 1'b0;
      oAck1   <= 1'b0;
      oMulA   <= '0;
      oMulB   <= '0;
      oValid  <= 1'b0;
      oResult <= '0;
      oId     <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            oMulA  <= winner ? iA1 : iA0;
            oMulB  <= winner ? iB1 : iB0;
            gnt    <= winner;
            rrLast <= winner;
            cnt    <= CNT_INIT;
            oAck0  <= ~winner;
            oAck1  <= winner;
            oBusy  <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            oResult <= iMulY;
            oId     <= gnt;
            oValid  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          oValid <= 1'b0;
          oBusy  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: vectors, directed corners and a random run
// checked against a transaction-level arbitration model.
module tb_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, req1, ack0, ack1;
  logic [3:0] a0, b0, a1, b1, mulA, mulB;
  logic [7:0] mulY, res;
  logic       valid, id, ready, busy;

  logic       cRst_n, cReq0, cReq1, cAck0, cAck1;
  logic [3:0] cA0, cB0, cA1, cB1, cMulA, cMulB;
  logic [7:0] cMulY, cRes;
  logic       cValid, cId, cReady, cBusy;

  assign mulY  = {4'd0, mulA} * {4'd0, mulB};
  assign cMulY = {4'd0, cMulA} * {4'd0, cMulB};

  mul_arbiter #(.WAIT_CYCLES(1)) dut (
    .iClock(clk), .iReset_n(rst_n),
    .iReq0(req0), .iA0(a0), .iB0(b0), .oAck0(ack0),
    .iReq1(req1), .iA1(a1), .iB1(b1), .oAck1(ack1),
    .oMulA(mulA), .oMulB(mulB), .iMulY(mulY),
    .oValid(valid), .oResult(res), .oId(id),
    .iReady(ready), .oBusy(busy)
  );

  mul_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .iClock(clk), .iReset_n(cRst_n),
    .iReq0(cReq0), .iA0(cA0), .iB0(cB0), .oAck0(cAck0),
    .iReq1(cReq1), .iA1(cA1), .iB1(cB1), .oAck1(cAck1),
    .oMulA(cMulA), .oMulB(cMulB), .iMulY(cMulY),
    .oValid(cValid), .oResult(cRes), .oId(cId),
    .iReady(cReady), .oBusy(cBusy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // transaction-level model state
  bit         outstanding;
  bit         lastW;
  int         q[$];
  int         cyc, gStep;
  logic       pv, pId;
  logic [7:0] pRes;

  // one clock; inputs seen now are the ones the edge used
  task automatic step();
    int e;
    bit w, g;
    @(posedge clk);
    #1;
    cyc++;
    g = !outstanding && (req0 || req1);
    w = (req0 && req1) ? !lastW : req1;
    chk("ack0", ack0, g && !w);
    chk("ack1", ack1, g && w);
    if (g) begin
      lastW = w;
      outstanding = 1;
      gStep = cyc;
      chk("mulA", mulA, w ? a1 : a0);
      chk("mulB", mulB, w ? b1 : b0);
      e = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
      q.push_back(e * 2 + int'(w));
    end
    if (valid && !pv) begin
      chk("validOwned", outstanding, 1);
      chk("latency", cyc - gStep, 1);
    end
    if (pv && ready) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL handshake: got result %0d expected none", pRes);
      end else begin
        e = q.pop_front();
        chk("result", pRes, e / 2);
        chk("id", pId, e % 2);
      end
      outstanding = 0;
      chk("validDrop", valid, 0);
    end else if (pv) begin
      chk("holdValid", valid, 1);
      chk("holdRes", res, pRes);
      chk("holdId", id, pId);
    end
    chk("busy", busy, outstanding);
    pv = valid;
    pRes = res;
    pId = id;
  endtask

  task automatic rst1();
    rst_n = 1'b0;
    #1;
    chk("rstOut", {ack0, ack1, valid, busy, id}, 0);
    chk("rstMul", {mulA, mulB}, 0);
    chk("rstRes", res, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outstanding = 0;
    lastW = 1;
    q.delete();
    pv = 0;
    pRes = 0;
    pId = 0;
  endtask

  task automatic waitAck(output bit w);
    bit ok = 0;
    w = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack0 || ack1) begin
        w = ack1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL ackTimeout: got no ack expected one");
    end
  endtask

  task automatic waitValid(output logic [7:0] r, output logic d);
    bit ok = 0;
    r = 0;
    d = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid) begin
        r = res;
        d = id;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL validTimeout: got no valid expected one");
    end
  endtask

  task automatic doOp(input bit r0, input bit r1,
                      input logic [3:0] x0, input logic [3:0] y0,
                      input logic [3:0] x1, input logic [3:0] y1,
                      output bit w, output logic [7:0] r,
                      output logic d);
    req0 = r0; req1 = r1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    waitAck(w);
    req0 = 0; req1 = 0;
    waitValid(r, d);
  endtask

  typedef struct {
    bit         r0, r1;
    logic [3:0] x0, y0, x1, y1;
    bit         expW;
    int         expRes;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit         w;
    logic [7:0] r;
    logic       d;

    tbl[0] = '{1, 0, 4'd3,  4'd5,  4'd0, 4'd0, 0, 15};
    tbl[1] = '{0, 1, 4'd0,  4'd0,  4'd2, 4'd7, 1, 14};
    tbl[2] = '{1, 1, 4'd15, 4'd15, 4'd2, 4'd7, 0, 225};
    tbl[3] = '{1, 1, 4'd15, 4'd15, 4'd2, 4'd7, 1, 14};
    tbl[4] = '{1, 1, 4'd9,  4'd9,  4'd4, 4'd4, 0, 81};
    tbl[5] = '{0, 1, 4'd0,  4'd0,  4'd15, 4'd1, 1, 15};

    rst_n = 0; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; ready = 1;
    cRst_n = 0; cReq0 = 0; cReq1 = 0;
    cA0 = 0; cB0 = 0; cA1 = 0; cB1 = 0; cReady = 1;
    cyc = 0; gStep = 0;
    repeat (2) @(posedge clk);
    #1;
    cRst_n = 1;
    rst1();

    foreach (tbl[k]) begin
      doOp(tbl[k].r0, tbl[k].r1, tbl[k].x0, tbl[k].y0,
           tbl[k].x1, tbl[k].y1, w, r, d);
      chk($sformatf("vec%0d.win", k), w, tbl[k].expW);
      chk($sformatf("vec%0d.res", k), r, tbl[k].expRes);
      chk($sformatf("vec%0d.id", k), d, tbl[k].expW);
    end
    step();

    rst1();
    req0 = 1; req1 = 1;
    a0 = 15; b0 = 15; a1 = 2; b1 = 7;
    waitAck(w);
    chk("tie.first", w, 0);
    req0 = 0;
    waitValid(r, d);
    chk("tie.res0", r, 225);
    chk("tie.id0", d, 0);
    waitAck(w);
    chk("tie.second", w, 1);
    req1 = 0;
    waitValid(r, d);
    chk("tie.res1", r, 14);
    chk("tie.id1", d, 1);
    step();

    rst1();
    req0 = 1; req1 = 1;
    a0 = 5; b0 = 6; a1 = 7; b1 = 3;
    for (int k = 0; k < 6; k++) begin
      waitAck(w);
      chk($sformatf("alt%0d", k), w, k % 2);
    end
    req0 = 0; req1 = 0;
    waitValid(r, d);
    chk("alt.lastId", d, 1);
    step();

    req0 = 1; a0 = 7; b0 = 9; ready = 0;
    waitAck(w);
    req0 = 0;
    waitValid(r, d);
    repeat (5) step();
    chk("stall.valid", valid, 1);
    chk("stall.res", res, 63);
    chk("stall.id", id, 0);
    ready = 1;
    step();
    chk("stall.drop", valid, 0);
    chk("stall.idle", busy, 0);

    for (int k = 0; k < 256; k++) begin
      doOp(k % 2 == 0, k % 2 == 1, 4'(k / 16), 4'(k % 16),
           4'(k / 16), 4'(k % 16), w, r, d);
      chk("sweep.res", r, (k / 16) * (k % 16));
      chk("sweep.id", d, k % 2);
    end
    step();

    rst1();
    for (int k = 0; k < 3000; k++) begin
      step();
      if (ack0) req0 = 0;
      else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1;
        a0 = 4'($urandom);
        b0 = 4'($urandom);
      end
      if (ack1) req1 = 0;
      else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1;
        a1 = 4'($urandom);
        b1 = 4'($urandom);
      end
      ready = ($urandom_range(3) != 0);
    end
    ready = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
    chk("drain", q.size(), 0);

    cReq0 = 1; cA0 = 4; cB0 = 6;
    @(posedge clk);
    #1;
    chk("w3.ack", cAck0, 1);
    cReq0 = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w3.valid%0d", k), cValid, k == 3);
    end
    chk("w3.res", cRes, 24);
    chk("w3.id", cId, 0);
    @(posedge clk);
    #1;
    chk("w3.done", {cValid, cBusy}, 0);

    cReq1 = 1; cA1 = 3; cB1 = 3;
    @(posedge clk);
    #1;
    chk("w3.ack1", cAck1, 1);
    cReq1 = 0;
    @(posedge clk);
    #1;
    cRst_n = 0;
    #1;
    chk("midRst.ctl", {cAck0, cAck1, cValid, cBusy, cId}, 0);
    chk("midRst.mul", {cMulA, cMulB}, 0);
    chk("midRst.res", cRes, 0);
    @(posedge clk);
    #1;
    cRst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("midRst.quiet", {cValid, cAck0, cAck1, cBusy}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
